// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch controller
//
// Contents:
//   state_t   : controller state (pause / run / adjust)
//   DIG_*     : scan index of each display digit, [3] = minute tens ... [0] = second ones

package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_ADJ   = 2'd2
    } state_t;

    localparam logic [1:0] DIG_MIN_T = 2'd3;
    localparam logic [1:0] DIG_MIN_O = 2'd2;
    localparam logic [1:0] DIG_SEC_T = 2'd1;
    localparam logic [1:0] DIG_SEC_O = 2'd0;

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter modulo MAX+1 with clear and wrap pulse
//
// Ports:
//   sclk  in   clock, rising edge
//   rst   in   synchronous active-high reset
//   inc   in   increment enable (one cycle)
//   clr   in   synchronous clear to 00, wins over inc
//   value out  {tens, ones} BCD count, registered
//   wrap  out  combinational: this cycle's increment takes the count MAX -> 00

module bcd_mod_counter #(
    parameter int unsigned MAX = 59
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       wrap
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MAX % 10);

    logic [3:0] tens;
    logic [3:0] ones;
    logic       at_max;

    assign value  = {tens, ones};
    assign at_max = (tens == MAX_T) && (ones == MAX_O);
    // A clear in the same cycle suppresses the carry so the next field is not bumped.
    assign wrap   = inc && at_max && !clr;

    always_ff @(posedge sclk) begin
        if (rst || clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/adjust sequencer, MM:SS counters and digit scan
//
// Ports:
//   sclk, rst        clock and synchronous active-high reset
//   tick_1hz         count enable in RUN
//   tick_2hz         adjust increment in ADJ, blink toggle in every state
//   tick_400hz       digit scan advance
//   btn_pause        press pulse, toggles the saved run flag
//   btn_reset        press pulse, clears MM:SS
//   sw_adj, sw_sel   adjust mode level; field select (0 = minutes, 1 = seconds)
//   min_bcd, sec_bcd {tens, ones} BCD time
//   digit_val        BCD value of the scanned digit for the shared decoder
//   anode            digit enables, [3] = minute tens ... [0] = second ones
//   running          saved run flag

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX       = 59,
    parameter int unsigned SEC_MAX       = 59,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_400hz,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [3:0] digit_val,
    output logic [3:0] anode,
    output logic       running
);

    localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'b1111 : 4'b0000;

    state_t     state;
    state_t     state_next;
    logic       run_flag_next;
    logic       blink_phase;
    logic [1:0] scan_idx;

    logic       sec_inc;
    logic       adj_min_inc;
    logic       min_inc;
    logic       sec_wrap;
    logic       min_wrap_unused;

    logic [3:0] scan_digit;
    logic       blank;
    logic [3:0] an_on;
    logic [3:0] anode_next;

    // ---------------- counters ----------------
    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .sclk  (sclk),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (btn_reset),
        .value (sec_bcd),
        .wrap  (sec_wrap)
    );

    // Minutes roll 59 -> 00 on their own; nothing beyond minutes consumes the carry.
    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .sclk  (sclk),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (btn_reset),
        .value (min_bcd),
        .wrap  (min_wrap_unused)
    );

    // Kept out of the FSM block so the seconds carry does not loop back into it.
    assign min_inc = (state == ST_RUN) ? sec_wrap : adj_min_inc;

    // ---------------- FSM ----------------
    always_ff @(posedge sclk) begin
        if (rst) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= run_flag_next;
        end
    end

    always_comb begin
        // The run flag toggles on every press; outside ADJ the state simply follows it,
        // inside ADJ it is only remembered for when the switch is released.
        run_flag_next = running ^ btn_pause;
        state_next    = run_flag_next ? ST_RUN : ST_PAUSE;
        sec_inc       = 1'b0;
        adj_min_inc   = 1'b0;
        if (sw_adj) begin
            state_next = ST_ADJ;
        end
        case (state)
            ST_RUN: begin
                sec_inc = tick_1hz;
            end
            ST_ADJ: begin
                sec_inc     = tick_2hz && sw_sel;
                adj_min_inc = tick_2hz && !sw_sel;
            end
            default: begin
            end
        endcase
    end

    // ---------------- digit scan ----------------
    always_comb begin
        scan_digit = 4'd0;
        case (scan_idx)
            DIG_MIN_T: scan_digit = min_bcd[7:4];
            DIG_MIN_O: scan_digit = min_bcd[3:0];
            DIG_SEC_T: scan_digit = sec_bcd[7:4];
            DIG_SEC_O: scan_digit = sec_bcd[3:0];
            default:   scan_digit = 4'd0;
        endcase
    end

    // Index bit 1 set means a minute digit; blank the selected field on the blink phase.
    assign blank      = (state == ST_ADJ) && blink_phase && (scan_idx[1] == !sw_sel);
    assign an_on      = blank ? 4'b0000 : (4'b0001 << scan_idx);
    assign anode_next = AN_ACTIVE_LOW ? ~an_on : an_on;

    always_ff @(posedge sclk) begin
        if (rst) begin
            blink_phase <= 1'b0;
            scan_idx    <= DIG_MIN_T;
            digit_val   <= 4'd0;
            anode       <= AN_OFF;
        end else begin
            if (tick_2hz) begin
                blink_phase <= !blink_phase;
            end
            // The digit shown is the one the index pointed at on the tick; the index
            // then moves on to the next digit.
            if (tick_400hz) begin
                digit_val <= scan_digit;
                anode     <= anode_next;
                scan_idx  <= scan_idx - 2'd1;
            end
        end
    end

endmodule
